alu_stack_seq: RTL and testbench
================================

# alu_stack_seq

Operand-stack sequencer that owns the shared 8-bit ALU in the stack-machine datapath. It accepts PUSH/POP/EXEC/CLR commands over a valid/ready handshake and holds a small LIFO operand stack. For EXEC it drives the ALU with the top two entries, then writes the result back onto the stack, or reports a branch decision for aluBE/aluBNE. It sits between instruction decode and the combinational ALU and is the only block that drives the ALU inputs.

## Interface
- DEPTH, 8: stack entries; power of 2, at least 2.
- W, 8: data width; must match the ALU width.
- CLK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command; 1 only in IDLE.
- cmd_kind  in  2  command kind: 00 PUSH, 01 POP, 10 EXEC, 11 CLR.
- cmd_op  in  3  ALU opcode for EXEC (definitions package encoding).
- cmd_data  in  W  PUSH value.
- alu_op  out  3  opcode to the ALU.
- alu_a  out  W  ALU operand A: next-on-stack (NOS).
- alu_b  out  W  ALU operand B: top-of-stack (TOS).
- alu_rslt  in  W  ALU result.
- alu_z  in  1  ALU branch flag.
- top  out  W  current TOS; 0 when the stack is empty.
- depth  out  $clog2(DEPTH)+1  number of valid entries.
- br_valid  out  1  one-cycle pulse when a branch EXEC completes.
- br_taken  out  1  valid only with br_valid; equals alu_z.
- err  out  1  sticky overflow/underflow flag.

## Operation
- A command is accepted on a rising edge with cmd_valid && cmd_ready. There is no buffering; a command held while cmd_ready=0 waits.
- States:
  - IDLE: accepts commands.
  - ISSUE: ALU inputs driven, result captured.
  - WB: stack updated.
- PUSH in IDLE:
  - If depth<DEPTH: write cmd_data at index depth; depth+1.
  - Otherwise: set err; stack unchanged.
- POP in IDLE:
  - If depth>0: depth-1.
  - Otherwise: set err.
- CLR in IDLE: depth=0, err=0. Stack contents are don't-care.
- EXEC in IDLE:
  - If depth<2: set err, stay in IDLE, stack unchanged.
  - Otherwise: latch cmd_op, NOS and TOS into operand registers; go to ISSUE.
- ISSUE (1 cycle):
  - alu_op, alu_a and alu_b come from the operand registers.
  - alu_rslt and alu_z are registered at the end of the cycle.
  - Go to WB.
- WB (1 cycle), op is not aluBE/aluBNE:
  - Pop 2, push the registered result; net depth-1.
  - New TOS = result, including the ALU default value 0xFF for undefined opcodes.
- WB (1 cycle), op is aluBE/aluBNE:
  - Pop 2; net depth-2.
  - br_valid=1 and br_taken=registered z for this cycle only.
- WB always returns to IDLE.
- Outside ISSUE: alu_op=3'b000, alu_a=0, alu_b=0.
- Arithmetic is performed entirely by the ALU at width W; the sequencer never modifies the result.
- Operand order is fixed: A=NOS, B=TOS. So SUB gives NOS-TOS and SL gives NOS<<TOS.
- err is set only by an ignored PUSH, POP or EXEC, and cleared only by CLR or reset.

## Timing
- Reset values: state IDLE, depth 0, top 0, err 0, br_valid 0, br_taken 0, alu_op/alu_a/alu_b 0, cmd_ready 1.
- PUSH/POP/CLR complete in one cycle. New depth and top are visible the cycle after acceptance, and cmd_ready stays 1.
- EXEC accepted at edge 0:
  - Cycle 1: ISSUE, cmd_ready=0.
  - Cycle 2: WB, cmd_ready=0, br_valid if a branch.
  - Cycle 3: top/depth updated, cmd_ready=1.
  - Back-to-back EXEC throughput is one per 3 cycles.
- top and depth are registered, with no combinational path from cmd_*.
- Only the alu_rslt/alu_z inputs feed the capture registers.
- Asynchronous reset in any state, including mid-EXEC: immediately forces the reset values. No br_valid is produced, and the in-flight EXEC is discarded.
- Ignored commands (overflow, underflow, EXEC with depth<2) still consume the handshake in one cycle.

## Test plan
- Add: PUSH 5, PUSH 3, EXEC aluADD -> alu_a=5, alu_b=3 during ISSUE; cycle 3 after EXEC: top=8, depth=1, err=0.
- Operand order: PUSH 3, PUSH 5, EXEC aluSUB -> top=0xFE. PUSH 1, PUSH 3, EXEC aluSL -> top=0x08.
- Branch:
  - PUSH 7, PUSH 7, EXEC aluBE -> single-cycle br_valid=1, br_taken=1 in WB; depth=0.
  - Repeat with aluBNE -> br_taken=0; top=0.
- Bounds:
  - 9 PUSHes of 1..9 -> depth=8, top=8, err=1.
  - CLR -> depth=0, err=0.
  - POP on empty -> err=1, depth=0.
- Short EXEC: PUSH 4, EXEC aluXOR -> err=1, depth=1, top=4, cmd_ready stays 1, no ISSUE (alu_op stays 0).
- Reset mid-op: PUSH 2, PUSH 2, EXEC aluBE, assert reset during ISSUE -> depth=0, top=0, br_valid never asserts, cmd_ready=1 after release.

Source files
------------

// File: rtl/alu_stack_seq.sv
// rtl/alu_stack_seq.sv - operand-stack sequencer driving the shared combinational ALU
module alu_stack_seq #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    localparam int IW   = $clog2(DEPTH),
    localparam int DW   = IW + 1
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_kind,
    input  logic [2:0]    cmd_op,
    input  logic [W-1:0]  cmd_data,
    output logic [2:0]    alu_op,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    input  logic [W-1:0]  alu_rslt,
    input  logic          alu_z,
    output logic [W-1:0]  top,
    output logic [DW-1:0] depth,
    output logic          br_valid,
    output logic          br_taken,
    output logic          err
);

    // Command kinds
    localparam logic [1:0] KIND_PUSH = 2'b00;
    localparam logic [1:0] KIND_POP  = 2'b01;
    localparam logic [1:0] KIND_EXEC = 2'b10;
    localparam logic [1:0] KIND_CLR  = 2'b11;

    // ALU opcodes that change how write-back behaves
    localparam logic [2:0] OP_BE  = 3'b110;
    localparam logic [2:0] OP_BNE = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WB    = 2'b10
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [W-1:0]   mem [DEPTH];
    logic [IW-1:0]  lo;
    logic           accept;
    logic           is_br;

    // Operand registers latched at EXEC acceptance, result registers at end of ISSUE
    logic [2:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   rslt_q;
    logic           z_q;

    // Stack write port
    logic           wr_en;
    logic [IW-1:0]  wr_idx;
    logic [W-1:0]   wr_data;

    // The low bits of depth address the stack; wrap-around is harmless because
    // every access is guarded by a depth comparison first.
    assign lo     = depth[IW-1:0];
    assign accept = cmd_valid && cmd_ready;
    assign is_br  = (op_q == OP_BE) || (op_q == OP_BNE);

    // State register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the state-decoded outputs (ALU drive, handshake, branch report)
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        alu_op     = 3'b000;
        alu_a      = '0;
        alu_b      = '0;
        br_valid   = 1'b0;
        br_taken   = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && (cmd_kind == KIND_EXEC) && (depth >= DW'(2))) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                alu_op     = op_q;
                alu_a      = a_q;
                alu_b      = b_q;
                state_next = S_WB;
            end
            S_WB: begin
                if (is_br) begin
                    br_valid = 1'b1;
                    br_taken = z_q;
                end
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Stack write request: PUSH in IDLE or ALU result in WB over the old NOS slot
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = lo;
        wr_data = cmd_data;
        if ((state == S_IDLE) && accept && (cmd_kind == KIND_PUSH) && (depth < DW'(DEPTH))) begin
            wr_en   = 1'b1;
            wr_idx  = lo;
            wr_data = cmd_data;
        end else if ((state == S_WB) && !is_br) begin
            wr_en   = 1'b1;
            wr_idx  = lo - IW'(2);
            wr_data = rslt_q;
        end
    end

    // Stack storage; contents are meaningless above depth so no reset is needed
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Depth, registered TOS copy, error flag and operand/result capture
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            depth  <= '0;
            top    <= '0;
            err    <= 1'b0;
            op_q   <= 3'b000;
            a_q    <= '0;
            b_q    <= '0;
            rslt_q <= '0;
            z_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (cmd_kind)
                            KIND_PUSH: begin
                                if (depth < DW'(DEPTH)) begin
                                    depth <= depth + DW'(1);
                                    top   <= cmd_data;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            KIND_POP: begin
                                if (depth != '0) begin
                                    depth <= depth - DW'(1);
                                    top   <= (depth >= DW'(2)) ? mem[lo - IW'(2)] : '0;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            KIND_EXEC: begin
                                if (depth >= DW'(2)) begin
                                    op_q <= cmd_op;
                                    a_q  <= mem[lo - IW'(2)];
                                    b_q  <= top;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            KIND_CLR: begin
                                depth <= '0;
                                top   <= '0;
                                err   <= 1'b0;
                            end
                            default: begin
                                err <= err;
                            end
                        endcase
                    end
                end
                S_ISSUE: begin
                    rslt_q <= alu_rslt;
                    z_q    <= alu_z;
                end
                S_WB: begin
                    if (is_br) begin
                        depth <= depth - DW'(2);
                        top   <= (depth >= DW'(3)) ? mem[lo - IW'(3)] : '0;
                    end else begin
                        depth <= depth - DW'(1);
                        top   <= rslt_q;
                    end
                end
                default: begin
                    depth <= depth;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stack_seq.sv
// tb/tb_alu_stack_seq.sv - self-checking bench for alu_stack_seq with a queue-based stack model
module tb_alu_stack_seq;

    localparam int DEPTH = 8;
    localparam int W     = 8;

    localparam logic [1:0] K_PUSH = 2'b00;
    localparam logic [1:0] K_POP  = 2'b01;
    localparam logic [1:0] K_EXEC = 2'b10;
    localparam logic [1:0] K_CLR  = 2'b11;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SL  = 3'b101;
    localparam logic [2:0] OP_BE  = 3'b110;
    localparam logic [2:0] OP_BNE = 3'b111;

    logic         CLK = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_kind;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_rslt;
    logic         alu_z;
    logic [W-1:0] top;
    logic [3:0]   depth;
    logic         br_valid;
    logic         br_taken;
    logic         err;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] stk[$];
    logic         err_m;

    always #5 CLK = ~CLK;

    alu_stack_seq #(.DEPTH(DEPTH), .W(W)) dut (
        .CLK(CLK), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_rslt(alu_rslt), .alu_z(alu_z),
        .top(top), .depth(depth),
        .br_valid(br_valid), .br_taken(br_taken), .err(err)
    );

    function automatic logic [W-1:0] ref_rslt(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SL:   r = a << b;
            default: r = 8'hFF;
        endcase
        return r;
    endfunction

    function automatic logic ref_z(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        if (op == OP_BE)  return a == b;
        if (op == OP_BNE) return a != b;
        return 1'b0;
    endfunction

    // External ALU that the sequencer drives
    assign alu_rslt = ref_rslt(alu_op, alu_a, alu_b);
    assign alu_z    = ref_z(alu_op, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_depth"}, depth, stk.size());
        check({tag, "_top"}, top, (stk.size() > 0) ? stk[$] : 8'h00);
        check({tag, "_err"}, err, err_m);
        check({tag, "_ready"}, cmd_ready, 1);
        check({tag, "_brv"}, br_valid, 0);
        check({tag, "_aluop"}, alu_op, 0);
    endtask

    task automatic step(input logic [1:0] kind, input logic [2:0] op, input logic [W-1:0] data);
        logic [W-1:0] a, b, er;
        logic ez, isbr;
        check("ready_pre", cmd_ready, 1);
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_kind  = kind;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        case (kind)
            K_PUSH: if (stk.size() < DEPTH) stk.push_back(data); else err_m = 1'b1;
            K_POP:  if (stk.size() > 0) void'(stk.pop_back()); else err_m = 1'b1;
            K_CLR:  begin stk.delete(); err_m = 1'b0; end
            default: begin
                if (stk.size() >= 2) begin
                    b  = stk.pop_back();
                    a  = stk.pop_back();
                    er = ref_rslt(op, a, b);
                    ez = ref_z(op, a, b);
                    isbr = (op == OP_BE) || (op == OP_BNE);
                    check("issue_op", alu_op, op);
                    check("issue_a", alu_a, a);
                    check("issue_b", alu_b, b);
                    check("issue_ready", cmd_ready, 0);
                    check("issue_brv", br_valid, 0);
                    @(posedge CLK);
                    #1;
                    check("wb_brv", br_valid, isbr);
                    if (isbr) check("wb_taken", br_taken, ez);
                    check("wb_ready", cmd_ready, 0);
                    check("wb_aluop", alu_op, 0);
                    if (!isbr) stk.push_back(er);
                    @(posedge CLK);
                    #1;
                end else begin
                    err_m = 1'b1;
                end
            end
        endcase
        check_state("post");
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_kind  = K_PUSH;
        cmd_op    = 3'b000;
        cmd_data  = '0;
        err_m     = 1'b0;
        #1;
        check("rst_depth", depth, 0);
        check("rst_top", top, 0);
        check("rst_err", err, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_brv", br_valid, 0);
        check("rst_brt", br_taken, 0);
        check("rst_a", alu_a, 0);
        check("rst_b", alu_b, 0);
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;

        // Add
        step(K_PUSH, 0, 8'd5);
        step(K_PUSH, 0, 8'd3);
        step(K_EXEC, OP_ADD, 0);
        check("add_top", top, 8'd8);
        check("add_depth", depth, 1);
        step(K_CLR, 0, 0);

        // Operand order
        step(K_PUSH, 0, 8'd3);
        step(K_PUSH, 0, 8'd5);
        step(K_EXEC, OP_SUB, 0);
        check("sub_top", top, 8'hFE);
        step(K_CLR, 0, 0);
        step(K_PUSH, 0, 8'd1);
        step(K_PUSH, 0, 8'd3);
        step(K_EXEC, OP_SL, 0);
        check("sl_top", top, 8'h08);
        step(K_CLR, 0, 0);

        // Branches
        step(K_PUSH, 0, 8'd7);
        step(K_PUSH, 0, 8'd7);
        step(K_EXEC, OP_BE, 0);
        check("be_depth", depth, 0);
        step(K_PUSH, 0, 8'd7);
        step(K_PUSH, 0, 8'd7);
        step(K_EXEC, OP_BNE, 0);
        check("bne_top", top, 0);

        // Overflow, clear, underflow
        for (int i = 1; i <= 9; i++) step(K_PUSH, 0, 8'(i));
        check("ovf_depth", depth, 8);
        check("ovf_top", top, 8);
        check("ovf_err", err, 1);
        step(K_CLR, 0, 0);
        check("clr_err", err, 0);
        step(K_POP, 0, 0);
        check("udf_err", err, 1);
        step(K_CLR, 0, 0);

        // Short EXEC
        step(K_PUSH, 0, 8'd4);
        step(K_EXEC, OP_XOR, 0);
        check("short_err", err, 1);
        check("short_top", top, 4);
        step(K_CLR, 0, 0);

        // Reset during ISSUE
        step(K_PUSH, 0, 8'd2);
        step(K_PUSH, 0, 8'd2);
        @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_kind  = K_EXEC;
        cmd_op    = OP_BE;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        check("mid_issue_op", alu_op, OP_BE);
        reset = 1'b1;
        #1;
        check("mid_depth", depth, 0);
        check("mid_top", top, 0);
        check("mid_brv", br_valid, 0);
        check("mid_ready", cmd_ready, 1);
        @(negedge CLK);
        reset = 1'b0;
        stk.delete();
        err_m = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            check("mid_no_br", br_valid, 0);
        end
        check_state("mid_after");

        // Randomised command stream against the queue model
        for (int n = 0; n < 300; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 3)      step(K_PUSH, 0, 8'($urandom));
            else if (r <= 5) step(K_POP, 0, 0);
            else if (r <= 8) step(K_EXEC, 3'($urandom_range(0, 7)), 0);
            else             step(K_CLR, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
